// File: rtl/mem_sram_pkg.sv
// Shared types and defaults for the 32-bit-to-16-bit async SRAM controller.
package mem_sram_pkg;

    localparam int unsigned SRAM_AW_DEF   = 18;
    localparam int unsigned SRAM_LAT_DEF  = 2;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    // Half-word select, appended as the SRAM address LSB (little-endian word)
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data memory front end: one 32-bit load/store becomes two
// sequenced half-word accesses on a 16-bit asynchronous SRAM, freezing the
// pipeline through `ready` while the access is in flight.
// Optional feature: MEM_SRAM_POSTED_WRITE_EN (writes complete in background).
module mem_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter int unsigned SRAM_LAT  = SRAM_LAT_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned SRAM_AW   = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned CW = $clog2(SRAM_LAT);
    localparam logic [CW-1:0] LAST = CW'(SRAM_LAT - 1);
    localparam int unsigned WW = SRAM_AW - 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [WW-1:0] widx, widx_nxt, widx_in;
    logic [31:0]   wdat, wdat_nxt;
    logic          op_wr, op_wr_nxt;
    logic [15:0]   rbuf_lo;
    logic          dq_oe, dq_oe_nxt;
    logic [SRAM_AW-1:0] addr_nxt;
    logic          we_n_nxt, oe_n_nxt;
    logic          cap_lo, cap_hi;
    logic          req, last;
    logic [31:0]   offs;
    logic [15:0]   wr_half;
    logic          unused_addr_bits;

    // Word index relative to the SRAM window; byte offset and high bits dropped
    assign offs             = address - BASE_ADDR;
    assign widx_in          = offs[SRAM_AW:2];
    assign unused_addr_bits = ^{offs[31:SRAM_AW+1], offs[1:0]};

    assign req  = rd_en | wr_en;
    assign last = (cnt == LAST);

    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    // Tri-state driver: selected half of the latched store word
    assign wr_half = (state == HI) ? wdat[31:16] : wdat[15:0];
    assign sram_dq = dq_oe ? wr_half : 16'hzzzz;

    // Next state, stall handshake and next-cycle SRAM strobes
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        widx_nxt  = widx;
        wdat_nxt  = wdat;
        op_wr_nxt = op_wr;
        ready     = 1'b0;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        addr_nxt  = sram_addr;
        we_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        dq_oe_nxt = 1'b0;

        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                    widx_nxt  = widx_in;
                    wdat_nxt  = wr_data;
                    op_wr_nxt = wr_en;
`ifdef MEM_SRAM_POSTED_WRITE_EN
                    ready     = wr_en;
`endif
                end
            end
            LO: begin
                if (last) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                    cap_lo    = ~op_wr;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HI: begin
                if (last) begin
                    cnt_nxt = '0;
                    cap_hi  = ~op_wr;
`ifdef MEM_SRAM_POSTED_WRITE_EN
                    state_nxt = op_wr ? IDLE : DONE;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Strobes for the coming cycle; WE released on the last cycle for hold time
        if (state_nxt == LO || state_nxt == HI) begin
            addr_nxt  = {widx_nxt, (state_nxt == HI) ? HALF_HI : HALF_LO};
            we_n_nxt  = ~(op_wr_nxt && (cnt_nxt != LAST));
            oe_n_nxt  = op_wr_nxt;
            dq_oe_nxt = op_wr_nxt;
        end
    end

    // State, latched request, registered strobes and read assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            widx      <= '0;
            wdat      <= '0;
            op_wr     <= 1'b0;
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            dq_oe     <= 1'b0;
            rbuf_lo   <= '0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            widx      <= widx_nxt;
            wdat      <= wdat_nxt;
            op_wr     <= op_wr_nxt;
            sram_addr <= addr_nxt;
            sram_we_n <= we_n_nxt;
            sram_oe_n <= oe_n_nxt;
            dq_oe     <= dq_oe_nxt;
            if (cap_lo) rbuf_lo <= sram_dq;
            if (cap_hi) rd_data <= {sram_dq, rbuf_lo};
        end
    end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

- Multi-cycle controller between the EXE/MEM pipeline register and the board's external 16-bit asynchronous SRAM.
- Converts one 32-bit word load or store into two sequenced half-word SRAM accesses.
- Drives `ready` low while an access is in flight so the pipeline freezes, then releases it for exactly one cycle when the access completes.
- Replaces the single-cycle data memory inside the MEM stage.

## Interface
Parameters:
- `SRAM_LAT`, 2: cycles per half-word phase; must be ≥2.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rd_en` in 1: load request (EXE/MEM `mem_r_en`).
- `wr_en` in 1: store request (EXE/MEM `mem_w_en`).
- `address` in 32: byte address (ALU result).
- `wr_data` in 32: store value.
- `rd_data` out 32: registered load result.
- `ready` out 1: 0 = freeze pipeline.
- `sram_dq` inout 16: SRAM data bus.
- `sram_addr` out SRAM_AW: SRAM address.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: SRAM strobes, active-low.

## Operation
- Word index `w = (address - BASE_ADDR) >> 2`. `address[1:0]` is ignored. The index is truncated to SRAM_AW-1 bits; no range check is made.
- Half-word addresses: low half at `{w,0}`, high half at `{w,1}`. Little-endian: the low half holds bits 15:0.
- FSM states:
  - IDLE: request seen → latch `w`, `wr_data`, and op, then go to LO.
  - LO: counter runs to SRAM_LAT → go to HI.
  - HI: counter runs to SRAM_LAT → go to DONE.
  - DONE: → IDLE unconditionally.
- If `wr_en` and `rd_en` are both high, the access is a write and `rd_en` is ignored.
- `ready` = 1 in IDLE with no request, and 1 in DONE. It is 0 in IDLE with a request, and 0 in LO and HI.
- DONE always returns to IDLE. The frozen request is still present in DONE, but it is never re-issued because the pipeline advances on that edge.
- Read phase:
  - `sram_oe_n`=0 and `sram_dq` is high-Z.
  - `sram_dq` is captured on the last cycle of the phase into the low half (LO) or high half (HI) of the read buffer.
  - `rd_data` loads from the read buffer on entry to DONE, then holds until the next read completes.
- Write phase:
  - `sram_dq` drives the selected half for all SRAM_LAT cycles.
  - `sram_we_n`=0 on every cycle except the last, which gives address and data hold time.
  - `sram_oe_n`=1.
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n` are tied to 0.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `rd_data`=0, `sram_addr`=0.
  - `sram_we_n`=1, `sram_oe_n`=1.
  - `sram_dq` high-Z.
  - `ready` follows its combinational rule, so it is 1 when there is no request.
- Stall: `ready` is low for 2·SRAM_LAT+1 cycles, then high for 1 cycle. With L=2 this is 5 low cycles plus 1 high cycle.
- `sram_addr`, `sram_we_n`, `sram_oe_n`, and the dq enable are registered outputs.
- Reset asserted mid-access: the FSM returns to IDLE immediately, `sram_we_n` goes to 1 and `sram_dq` is released asynchronously. A partially written word is left as is.
- Requests that arrive in LO, HI, or DONE are not sampled; only IDLE samples.

## Configuration
- `MEM_SRAM_POSTED_WRITE_EN`: defined (posted writes enabled):
  - A write in IDLE is latched with `ready`=1 in the same cycle and completes in the background as LO → HI → IDLE, with no DONE state.
  - Any request arriving while the FSM is not in IDLE sees `ready`=0 until the FSM returns to IDLE. The request is then accepted normally.
  - Reads are unchanged.
- `MEM_SRAM_POSTED_WRITE_EN`: undefined: writes stall the pipeline exactly like reads.

## Structure
- Package `mem_sram_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the half-select constants;
  - the default SRAM_AW, SRAM_LAT and BASE_ADDR values.
- One module; no sub-module is warranted. The phase counter and tri-state driver are inline.

## Test plan
- Write 0x12345678 to address 1024, L=2 → SRAM[0]=0x5678 and SRAM[1]=0x1234; `ready` low 5 cycles then high 1; `sram_we_n` low exactly 1 cycle per phase.
- Read address 1024 after that write → `rd_data`=0x12345678 from the DONE cycle onward; `sram_dq` never driven by the controller.
- Read address 1030 → `sram_addr` sequence 2 then 3 (`address[1:0]` ignored).
- Assert `wr_en` and `rd_en` together with address 1028 and data 0xDEADBEEF → SRAM[2]=0xBEEF and SRAM[3]=0xDEAD; `rd_data` unchanged.
- Drop `rst` to 0 during the HI phase of a write → same cycle: `sram_we_n`=1, dq high-Z, `rd_data`=0; after release the FSM is in IDLE and the next read completes normally.
- With `MEM_SRAM_POSTED_WRITE_EN` defined: write followed next cycle by a read → write shows `ready`=1, the read sees `ready`=0 for 2·L cycles of write drain plus its own 2·L+1 cycles, then returns the written value.
